// File: rtl/car_speed_ctrl.sv
// Four-level vehicle speed controller: one registered step per clock from key, brake and accelerator.
// Brake outranks accelerator, and a key-off forces STOP from any state.
module car_speed_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       keys,
    input  logic       brake,
    input  logic       accelerate,
    output logic [1:0] speed
);

    typedef enum logic [1:0] {
        STOP   = 2'b00,
        SLOW   = 2'b01,
        MEDIUM = 2'b10,
        FAST   = 2'b11
    } speed_e;

    speed_e speed_q;

    // Both pedal steps saturate, so STOP absorbs brake and FAST absorbs accelerate.
    always_ff @(posedge clock) begin
        if (reset) begin
            speed_q <= STOP;
        end else if (!keys) begin
            speed_q <= STOP;
        end else if (brake) begin
            case (speed_q)
                FAST:    speed_q <= MEDIUM;
                MEDIUM:  speed_q <= SLOW;
                default: speed_q <= STOP;
            endcase
        end else if (accelerate) begin
            case (speed_q)
                STOP:    speed_q <= SLOW;
                SLOW:    speed_q <= MEDIUM;
                default: speed_q <= FAST;
            endcase
        end
    end

    assign speed = speed_q;

endmodule

// File: tb/tb_car_speed_ctrl.sv
// Self-checking bench for car_speed_ctrl: an integer speed-level model compared on every
// falling edge, plus directed vectors carrying hand-computed expected speeds.
module tb_car_speed_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       keys = 1'b1;
    logic       brake = 1'b0;
    logic       accelerate = 1'b0;
    logic [1:0] speed;

    int checks = 0;
    int failures = 0;
    int modelLevel = 0;
    bit modelValid = 1'b0;
    bit benchDone = 1'b0;

    car_speed_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .keys       (keys),
        .brake      (brake),
        .accelerate (accelerate),
        .speed      (speed)
    );

    always #5 clock = ~clock;

    // The model treats speed as a plain level 0..3 and clamps each pedal step to that range.
    always @(posedge clock) begin
        if (reset) begin
            modelLevel = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (!keys)
                modelLevel = 0;
            else if (brake)
                modelLevel = (modelLevel > 0) ? modelLevel - 1 : 0;
            else if (accelerate)
                modelLevel = (modelLevel < 3) ? modelLevel + 1 : 3;
        end
    end

    always @(negedge clock) begin
        if (modelValid && !benchDone) begin
            checks++;
            if (speed !== 2'(modelLevel)) begin
                failures++;
                $display("[TB] FAIL model_compare t=%0t actual=%b expected=%b", $time, speed, 2'(modelLevel));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [1:0] expected);
        checks++;
        if (speed !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, speed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, well away from the sampling edge.
    task automatic applyStimulus(input string name, input logic rst, input logic key,
                                 input logic brk, input logic acc, input logic [1:0] expected);
        reset = rst;
        keys = key;
        brake = brk;
        accelerate = acc;
        @(posedge clock);
        #1;
        checkOutput(name, expected);
    endtask

    initial begin
        #1;
        applyStimulus("reset_hold0", 1, 1, 0, 1, 2'b00);
        applyStimulus("reset_hold1", 1, 1, 0, 1, 2'b00);

        applyStimulus("ramp0", 0, 1, 0, 1, 2'b01);
        applyStimulus("ramp1", 0, 1, 0, 1, 2'b10);
        applyStimulus("ramp2", 0, 1, 0, 1, 2'b11);
        applyStimulus("ramp3_sat", 0, 1, 0, 1, 2'b11);
        applyStimulus("ramp4_sat", 0, 1, 0, 1, 2'b11);

        applyStimulus("brake_to_medium", 0, 1, 1, 0, 2'b10);
        applyStimulus("both0", 0, 1, 1, 1, 2'b01);
        applyStimulus("both1", 0, 1, 1, 1, 2'b00);
        applyStimulus("both2_sat", 0, 1, 1, 1, 2'b00);
        applyStimulus("accel_after_brake", 0, 1, 0, 1, 2'b01);

        applyStimulus("up_medium", 0, 1, 0, 1, 2'b10);
        applyStimulus("up_fast", 0, 1, 0, 1, 2'b11);
        applyStimulus("key_off_fast", 0, 0, 0, 1, 2'b00);
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("key_off_hold%0d", i), 0, 0, i[0], ~i[0], 2'b00);
        applyStimulus("key_on_idle", 0, 1, 0, 0, 2'b00);
        applyStimulus("key_on_accel", 0, 1, 0, 1, 2'b01);

        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("idle_slow%0d", i), 0, 1, 0, 0, 2'b01);
        applyStimulus("idle_brake0", 0, 1, 1, 0, 2'b00);
        applyStimulus("idle_brake1_sat", 0, 1, 1, 0, 2'b00);

        applyStimulus("mid_up0", 0, 1, 0, 1, 2'b01);
        applyStimulus("mid_up1", 0, 1, 0, 1, 2'b10);
        applyStimulus("mid_up2", 0, 1, 0, 1, 2'b11);
        applyStimulus("mid_reset", 1, 1, 0, 1, 2'b00);
        applyStimulus("post_reset_accel", 0, 1, 0, 1, 2'b01);

        benchDone = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
